// File: rtl/fxp_round_sat_pipe_pkg.sv
// Shared fixed-point definitions: default widths, rounding-mode enum and the
// legacy half-up rounding function kept as the reference for RND_HALF_UP.
package fxp_round_sat_pipe_pkg;

    localparam int unsigned FXP_MAX_WIDTH            = 64;
    localparam int unsigned FXP_SHIFT_WIDTH          = $clog2(FXP_MAX_WIDTH);
    localparam int unsigned JACOBI_OUTPUT_WORD_WIDTH = 20;
    localparam int unsigned JACOBI_PAIR              = 2;

    typedef enum logic [1:0] {
        RND_TRUNC,
        RND_HALF_UP,
        RND_CONV,
        RND_HALF_AWAY
    } rnd_mode_t;

    // Legacy rounding: (x + 2^(n-1)) >>> n in FXP_MAX_WIDTH bits; wraps at the positive extreme.
    function automatic logic signed [FXP_MAX_WIDTH-1:0] fxp_round(
        input logic signed [FXP_MAX_WIDTH-1:0] x,
        input logic [FXP_SHIFT_WIDTH-1:0]      n
    );
        logic signed [FXP_MAX_WIDTH-1:0] h;
        h = (n == '0) ? '0 : (FXP_MAX_WIDTH'(1) << (n - FXP_SHIFT_WIDTH'(1)));
        return (x + h) >>> n;
    endfunction

endpackage

// File: rtl/fxp_round_sat_pipe_lane.sv
// One combinational rescaler lane: a round stage (x, shift, mode -> rounded)
// and a separate narrow stage (rounded, sat_en -> narrowed word, overflow).
module fxp_round_lane
    import fxp_round_sat_pipe_pkg::*;
#(
    parameter int unsigned IN_WIDTH    = FXP_MAX_WIDTH,
    parameter int unsigned OUT_WIDTH   = JACOBI_OUTPUT_WORD_WIDTH,
    parameter int unsigned SHIFT_WIDTH = $clog2(IN_WIDTH)
) (
    input  logic signed [IN_WIDTH-1:0]  x_i,
    input  logic [SHIFT_WIDTH-1:0]      shift_i,
    input  rnd_mode_t                   mode_i,
    output logic signed [IN_WIDTH:0]    rnd_o,
    input  logic signed [IN_WIDTH:0]    rnd_i,
    input  logic                        sat_en_i,
    output logic signed [OUT_WIDTH-1:0] narrow_o,
    output logic                        ovf_o
);

    localparam int unsigned XW = IN_WIDTH + 1;
    localparam int unsigned HW = IN_WIDTH - OUT_WIDTH + 2;
    localparam logic [SHIFT_WIDTH-1:0]      N_MAX   = SHIFT_WIDTH'(IN_WIDTH - 1);
    localparam logic [XW-1:0]               ONES    = '1;
    localparam logic [XW-1:0]               ONE     = XW'(1);
    localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic [SHIFT_WIDTH-1:0] n;
    logic signed [XW-1:0]   xe;
    logic signed [XW-1:0]   q;
    logic [XW-1:0]          r;
    logic [XW-1:0]          h;
    logic                   tie;
    logic                   above;
    logic                   inc;
    logic [HW-1:0]          hi;

    // Round stage: one extra bit of headroom, so q+1 can never wrap.
    always_comb begin
        n     = (shift_i > N_MAX) ? N_MAX : shift_i;
        xe    = {x_i[IN_WIDTH-1], x_i};
        q     = xe >>> n;
        r     = $unsigned(xe) & ~(ONES << n);
        h     = (n == '0) ? '0 : (ONE << (n - SHIFT_WIDTH'(1)));
        tie   = (r == h);
        above = (r > h);
        case (mode_i)
            RND_TRUNC:     inc = 1'b0;
            RND_HALF_UP:   inc = above || tie;
            RND_CONV:      inc = above || (tie && q[0]);
            RND_HALF_AWAY: inc = above || (tie && !x_i[IN_WIDTH-1]);
            default:       inc = 1'b0;
        endcase
        if (n == '0) begin
            inc = 1'b0;
        end
        rnd_o = inc ? (q + XW'(1)) : q;
    end

    // Narrow stage: in range iff every bit from the sign down to bit OUT_WIDTH-1 agrees.
    always_comb begin
        hi    = rnd_i[IN_WIDTH:OUT_WIDTH-1];
        ovf_o = !((&hi) || !(|hi));
        if (ovf_o && sat_en_i) begin
            narrow_o = rnd_i[IN_WIDTH] ? OUT_MIN : OUT_MAX;
        end else begin
            narrow_o = rnd_i[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/fxp_round_sat_pipe.sv
// Two-stage multi-lane fixed-point rescaler with valid/ready backpressure,
// per-lane overflow flags and sticky overflow accumulation.
module fxp_round_sat_pipe
    import fxp_round_sat_pipe_pkg::*;
#(
    parameter int unsigned IN_WIDTH    = FXP_MAX_WIDTH,
    parameter int unsigned OUT_WIDTH   = JACOBI_OUTPUT_WORD_WIDTH,
    parameter int unsigned N_LANES     = JACOBI_PAIR,
    parameter int unsigned SHIFT_WIDTH = $clog2(IN_WIDTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N_LANES*IN_WIDTH-1:0]    in_data,
    input  logic [SHIFT_WIDTH-1:0]         shift,
    input  rnd_mode_t                      mode,
    input  logic                           sat_en,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [N_LANES*OUT_WIDTH-1:0]   out_data,
    output logic [N_LANES-1:0]             out_ovf,
    output logic [N_LANES-1:0]             ovf_sticky,
    input  logic                           ovf_clear
);

    localparam int unsigned XW = IN_WIDTH + 1;

    logic signed [XW-1:0]         rnd_d [N_LANES];
    logic signed [XW-1:0]         rnd_q [N_LANES];
    logic                         sat_q;
    logic                         v1_q;
    logic [N_LANES*OUT_WIDTH-1:0] data_d;
    logic [N_LANES*OUT_WIDTH-1:0] data_q;
    logic [N_LANES-1:0]           ovf_d;
    logic [N_LANES-1:0]           ovf_q;
    logic                         v2_q;
    logic [N_LANES-1:0]           sticky_d;
    logic [N_LANES-1:0]           sticky_q;
    logic                         adv1;
    logic                         adv2;

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        fxp_round_lane #(
            .IN_WIDTH    (IN_WIDTH),
            .OUT_WIDTH   (OUT_WIDTH),
            .SHIFT_WIDTH (SHIFT_WIDTH)
        ) u_lane (
            .x_i      (in_data[k*IN_WIDTH +: IN_WIDTH]),
            .shift_i  (shift),
            .mode_i   (mode),
            .rnd_o    (rnd_d[k]),
            .rnd_i    (rnd_q[k]),
            .sat_en_i (sat_q),
            .narrow_o (data_d[k*OUT_WIDTH +: OUT_WIDTH]),
            .ovf_o    (ovf_d[k])
        );
    end

    // out_ready reaches in_ready combinationally so an empty S1 never waits on a stalled S2.
    always_comb begin
        adv2     = !v2_q || out_ready;
        adv1     = !v1_q || adv2;
        in_ready = adv1 && !rst;
        sticky_d = ovf_clear ? '0 : sticky_q;
        if (v2_q && out_ready) begin
            sticky_d = sticky_d | ovf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < N_LANES; k++) begin
                rnd_q[k] <= '0;
            end
            sat_q    <= 1'b0;
            v1_q     <= 1'b0;
            data_q   <= '0;
            ovf_q    <= '0;
            v2_q     <= 1'b0;
            sticky_q <= '0;
        end else begin
            if (adv1) begin
                v1_q <= in_valid;
                if (in_valid) begin
                    rnd_q <= rnd_d;
                    sat_q <= sat_en;
                end
            end
            if (adv2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    data_q <= data_d;
                    ovf_q  <= ovf_d;
                end
            end
            sticky_q <= sticky_d;
        end
    end

    assign out_valid  = v2_q;
    assign out_data   = data_q;
    assign out_ovf    = ovf_q;
    assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_fxp_round_sat_pipe.sv
// Directed self-checking bench for fxp_round_sat_pipe (64-bit in, 20-bit out, 2 lanes, 7-bit shift).
module tb_fxp_round_sat_pipe;
    import fxp_round_sat_pipe_pkg::*;

    localparam int unsigned IW = 64;
    localparam int unsigned OW = 20;
    localparam int unsigned NL = 2;
    localparam int unsigned SW = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [NL*IW-1:0] in_data;
    logic [SW-1:0]    shift;
    rnd_mode_t        mode;
    logic             sat_en;
    logic             out_valid;
    logic             out_ready;
    logic [NL*OW-1:0] out_data;
    logic [NL-1:0]    out_ovf;
    logic [NL-1:0]    ovf_sticky;
    logic             ovf_clear;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fxp_round_sat_pipe #(
        .IN_WIDTH    (IW),
        .OUT_WIDTH   (OW),
        .N_LANES     (NL),
        .SHIFT_WIDTH (SW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .shift      (shift),
        .mode       (mode),
        .sat_en     (sat_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ovf    (out_ovf),
        .ovf_sticky (ovf_sticky),
        .ovf_clear  (ovf_clear)
    );

    // Sends one beat into an empty pipe, waits (bounded) for it, and returns after it has transferred.
    task automatic run_beat(input logic [IW-1:0] x0, input logic [IW-1:0] x1,
                            input logic [SW-1:0] n, input rnd_mode_t m, input logic s,
                            input logic clr,
                            output logic signed [OW-1:0] d0, output logic signed [OW-1:0] d1,
                            output logic [NL-1:0] ov, output logic ok);
        ok = 1'b0; d0 = '0; d1 = '0; ov = '0;
        @(negedge clk);
        in_valid = 1'b1; in_data = {x1, x0}; shift = n; mode = m; sat_en = s; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (out_valid) begin
                ok = 1'b1;
                d0 = out_data[OW-1:0];
                d1 = out_data[2*OW-1:OW];
                ov = out_ovf;
                ovf_clear = clr;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        ovf_clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ovf_clear = 1'b0;
        in_data = '0; shift = '0; mode = RND_TRUNC; sat_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        tests++; if (out_data !== '0) begin fails++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        tests++; if (out_ovf !== '0) begin fails++; $display("FAIL reset_out_ovf: got %b want 00", out_ovf); end
        tests++; if (ovf_sticky !== '0) begin fails++; $display("FAIL reset_sticky: got %b want 00", ovf_sticky); end
    endtask

    task automatic test_rounding();
        logic [IW-1:0]      xs [3];
        int                 e0 [3][4];
        int                 e1 [3][4];
        logic signed [OW-1:0] d0, d1;
        logic [NL-1:0]      ov;
        logic               ok;
        xs = '{64'h4000, 64'h14000, 64'h6000};
        e0 = '{'{0, 1, 0, 1}, '{2, 3, 2, 3}, '{0, 1, 1, 1}};
        e1 = '{'{-1, 0, 0, -1}, '{-3, -2, -2, -3}, '{-1, -1, -1, -1}};
        for (int r = 0; r < 3; r++) begin
            for (int m = 0; m < 4; m++) begin
                run_beat(xs[r], -xs[r], SW'(15), rnd_mode_t'(m), 1'b1, 1'b0, d0, d1, ov, ok);
                tests++; if (!ok) begin fails++; $display("FAIL round_timeout r%0d m%0d: got no out_valid want out_valid", r, m); end
                tests++; if (d0 !== OW'(e0[r][m])) begin fails++; $display("FAIL round_l0 r%0d m%0d: got %0d want %0d", r, m, d0, e0[r][m]); end
                tests++; if (d1 !== OW'(e1[r][m])) begin fails++; $display("FAIL round_l1 r%0d m%0d: got %0d want %0d", r, m, d1, e1[r][m]); end
                tests++; if (ov !== 2'b00) begin fails++; $display("FAIL round_ovf r%0d m%0d: got %b want 00", r, m, ov); end
            end
        end
    endtask

    task automatic test_saturation();
        logic [IW-1:0]      x0 [4];
        logic [IW-1:0]      x1 [4];
        logic               sv [4];
        int                 e0 [4];
        int                 e1 [4];
        logic [NL-1:0]      eo [4];
        logic signed [OW-1:0] d0, d1;
        logic [NL-1:0]      ov;
        logic               ok;
        x0[0] = 64'd1 << 40;        x1[0] = -(64'd1 << 40);       sv[0] = 1'b1; e0[0] = 524287;  e1[0] = -524288; eo[0] = 2'b11;
        x0[1] = 64'd1 << 40;        x1[1] = -(64'd1 << 40);       sv[1] = 1'b0; e0[1] = 0;       e1[1] = 0;       eo[1] = 2'b11;
        x0[2] = 64'd524287 << 15;   x1[2] = -(64'd524288 << 15);  sv[2] = 1'b0; e0[2] = 524287;  e1[2] = -524288; eo[2] = 2'b00;
        x0[3] = 64'd524288 << 15;   x1[3] = -(64'd524289 << 15);  sv[3] = 1'b0; e0[3] = -524288; e1[3] = 524287;  eo[3] = 2'b11;
        for (int i = 0; i < 4; i++) begin
            run_beat(x0[i], x1[i], SW'(15), RND_TRUNC, sv[i], 1'b0, d0, d1, ov, ok);
            tests++; if (!ok) begin fails++; $display("FAIL sat_timeout v%0d: got no out_valid want out_valid", i); end
            tests++; if (d0 !== OW'(e0[i])) begin fails++; $display("FAIL sat_l0 v%0d: got %0d want %0d", i, d0, e0[i]); end
            tests++; if (d1 !== OW'(e1[i])) begin fails++; $display("FAIL sat_l1 v%0d: got %0d want %0d", i, d1, e1[i]); end
            tests++; if (ov !== eo[i]) begin fails++; $display("FAIL sat_ovf v%0d: got %b want %b", i, ov, eo[i]); end
        end
    endtask

    task automatic test_edge_shifts();
        logic [IW-1:0]      x0 [4];
        logic [IW-1:0]      x1 [4];
        logic [SW-1:0]      nv [4];
        rnd_mode_t          mv [4];
        int                 e0 [4];
        int                 e1 [4];
        logic [NL-1:0]      eo [4];
        logic signed [OW-1:0] d0, d1;
        logic [NL-1:0]      ov;
        logic               ok;
        for (int m = 0; m < 4; m++) begin
            run_beat(64'd12345, -64'd12345, SW'(0), rnd_mode_t'(m), 1'b1, 1'b0, d0, d1, ov, ok);
            tests++; if (!ok) begin fails++; $display("FAIL n0_timeout m%0d: got no out_valid want out_valid", m); end
            tests++; if (d0 !== OW'(12345)) begin fails++; $display("FAIL n0_l0 m%0d: got %0d want 12345", m, d0); end
            tests++; if (d1 !== OW'(-12345)) begin fails++; $display("FAIL n0_l1 m%0d: got %0d want -12345", m, d1); end
            tests++; if (ov !== 2'b00) begin fails++; $display("FAIL n0_ovf m%0d: got %b want 00", m, ov); end
        end
        x0[0] = 64'h8000_0000_0000_0000; x1[0] = 64'h4000_0000_0000_0000; nv[0] = SW'(63); mv[0] = RND_HALF_UP;
        e0[0] = -1;     e1[0] = 1;       eo[0] = 2'b00;
        x0[1] = 64'h4000_0000_0000_0000; x1[1] = 64'h6000_0000_0000_0000; nv[1] = SW'(63); mv[1] = RND_CONV;
        e0[1] = 0;      e1[1] = 1;       eo[1] = 2'b00;
        x0[2] = 64'h4000_0000_0000_0000; x1[2] = 64'h6000_0000_0000_0000; nv[2] = SW'(70); mv[2] = RND_CONV;
        e0[2] = 0;      e1[2] = 1;       eo[2] = 2'b00;
        x0[3] = 64'h7FFF_FFFF_FFFF_FFFF; x1[3] = 64'h8000_0000_0000_0000; nv[3] = SW'(1);  mv[3] = RND_HALF_UP;
        e0[3] = 524287; e1[3] = -524288; eo[3] = 2'b11;
        for (int i = 0; i < 4; i++) begin
            run_beat(x0[i], x1[i], nv[i], mv[i], 1'b1, 1'b0, d0, d1, ov, ok);
            tests++; if (!ok) begin fails++; $display("FAIL edge_timeout v%0d: got no out_valid want out_valid", i); end
            tests++; if (d0 !== OW'(e0[i])) begin fails++; $display("FAIL edge_l0 v%0d: got %0d want %0d", i, d0, e0[i]); end
            tests++; if (d1 !== OW'(e1[i])) begin fails++; $display("FAIL edge_l1 v%0d: got %0d want %0d", i, d1, e1[i]); end
            tests++; if (ov !== eo[i]) begin fails++; $display("FAIL edge_ovf v%0d: got %b want %b", i, ov, eo[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [IW-1:0] a, b;
        logic          ev;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1; shift = '0; mode = RND_TRUNC; sat_en = 1'b1;
            if (cyc < 4) begin
                a = IW'(cyc * 1000 + 7);
                b = IW'(-(cyc + 1) * 3);
                in_valid = 1'b1; in_data = {b, a};
            end else begin
                in_valid = 1'b0;
            end
            #1;
            ev = (cyc >= 2) && (cyc < 6);
            tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready c%0d: got %b want 1", cyc, in_ready); end
            tests++; if (out_valid !== ev) begin fails++; $display("FAIL b2b_out_valid c%0d: got %b want %b", cyc, out_valid, ev); end
            if (ev) begin
                tests++;
                if (out_data[OW-1:0] !== OW'((cyc - 2) * 1000 + 7)) begin
                    fails++; $display("FAIL b2b_l0 c%0d: got %0d want %0d", cyc, $signed(out_data[OW-1:0]), (cyc - 2) * 1000 + 7);
                end
                tests++;
                if (out_data[2*OW-1:OW] !== OW'(-(cyc - 1) * 3)) begin
                    fails++; $display("FAIL b2b_l1 c%0d: got %0d want %0d", cyc, $signed(out_data[2*OW-1:OW]), -(cyc - 1) * 3);
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int            sent = 0;
        int            rcvd = 0;
        int            acc_stall = 0;
        logic [IW-1:0] a, b;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 5); shift = '0; mode = RND_TRUNC; sat_en = 1'b1;
            in_valid  = (sent < 6);
            a = IW'(100 + sent);
            b = IW'(-(sent + 1));
            in_data = {b, a};
            #1;
            if (cyc < 5) begin
                if (in_valid && in_ready) acc_stall++;
                if (cyc >= 2) begin
                    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready c%0d: got %b want 0", cyc, in_ready); end
                    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_valid c%0d: got %b want 1", cyc, out_valid); end
                    tests++; if (out_data !== {20'hFFFFF, 20'd100}) begin fails++; $display("FAIL bp_hold_data c%0d: got %h want %h", cyc, out_data, {20'hFFFFF, 20'd100}); end
                end
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                tests++;
                if (out_data[OW-1:0] !== OW'(100 + rcvd)) begin
                    fails++; $display("FAIL bp_order_l0 b%0d: got %0d want %0d", rcvd, $signed(out_data[OW-1:0]), 100 + rcvd);
                end
                tests++;
                if (out_data[2*OW-1:OW] !== OW'(-(rcvd + 1))) begin
                    fails++; $display("FAIL bp_order_l1 b%0d: got %0d want %0d", rcvd, $signed(out_data[2*OW-1:OW]), -(rcvd + 1));
                end
                rcvd++;
            end
            if (rcvd == 6) break;
        end
        in_valid = 1'b0;
        tests++; if (acc_stall !== 2) begin fails++; $display("FAIL bp_accepted_in_stall: got %0d want 2", acc_stall); end
        tests++; if (rcvd !== 6) begin fails++; $display("FAIL bp_received: got %0d want 6", rcvd); end
    endtask

    task automatic test_sticky();
        logic signed [OW-1:0] d0, d1;
        logic [NL-1:0]        ov;
        logic                 ok;
        @(negedge clk); ovf_clear = 1'b1;
        @(negedge clk); ovf_clear = 1'b0;
        run_beat(64'd5, 64'd1 << 40, SW'(0), RND_TRUNC, 1'b1, 1'b0, d0, d1, ov, ok);
        #1;
        tests++; if (!ok || ov !== 2'b10) begin fails++; $display("FAIL sticky_beat_ovf: got ok=%b ovf=%b want ok=1 ovf=10", ok, ov); end
        tests++; if (ovf_sticky !== 2'b10) begin fails++; $display("FAIL sticky_set_l1: got %b want 10", ovf_sticky); end
        @(negedge clk); ovf_clear = 1'b1;
        @(negedge clk); ovf_clear = 1'b0;
        #1;
        tests++; if (ovf_sticky !== 2'b00) begin fails++; $display("FAIL sticky_clear: got %b want 00", ovf_sticky); end
        run_beat(64'd5, 64'd1 << 40, SW'(0), RND_TRUNC, 1'b1, 1'b0, d0, d1, ov, ok);
        #1;
        tests++; if (ovf_sticky !== 2'b10) begin fails++; $display("FAIL sticky_reset_l1: got %b want 10", ovf_sticky); end
        run_beat(64'd5, 64'd1 << 40, SW'(0), RND_TRUNC, 1'b1, 1'b1, d0, d1, ov, ok);
        #1;
        tests++; if (ovf_sticky !== 2'b10) begin fails++; $display("FAIL sticky_set_wins_same: got %b want 10", ovf_sticky); end
        run_beat(64'd1 << 40, 64'd5, SW'(0), RND_TRUNC, 1'b1, 1'b1, d0, d1, ov, ok);
        #1;
        tests++; if (ovf_sticky !== 2'b01) begin fails++; $display("FAIL sticky_set_wins_other: got %b want 01", ovf_sticky); end
    endtask

    task automatic test_reset_midstream();
        int                   seen = 0;
        logic signed [OW-1:0] d0, d1;
        logic [NL-1:0]        ov;
        logic                 ok;
        shift = '0; mode = RND_TRUNC; sat_en = 1'b1; out_ready = 1'b0;
        @(negedge clk); in_valid = 1'b1; in_data = {64'd11, 64'd1 << 40};
        @(negedge clk); in_valid = 1'b1; in_data = {64'd1 << 40, 64'd22};
        @(negedge clk); in_valid = 1'b1; in_data = {64'd33, 64'd33}; rst = 1'b1;
        @(negedge clk); in_valid = 1'b0; rst = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); end
        tests++; if (ovf_sticky !== 2'b00) begin fails++; $display("FAIL rst_mid_sticky: got %b want 00", ovf_sticky); end
        tests++; if (out_data !== '0) begin fails++; $display("FAIL rst_mid_out_data: got %h want 0", out_data); end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            if (out_valid) seen++;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL rst_mid_ghost_beats: got %0d want 0", seen); end
        run_beat(64'd77, -64'd77, SW'(0), RND_TRUNC, 1'b1, 1'b0, d0, d1, ov, ok);
        tests++; if (!ok || d0 !== OW'(77) || d1 !== OW'(-77)) begin
            fails++; $display("FAIL rst_mid_recover: got ok=%b %0d/%0d want ok=1 77/-77", ok, d0, d1);
        end
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_saturation();
        test_edge_shifts();
        test_back_to_back();
        test_backpressure();
        test_sticky();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fxp_round_sat_pipe.md
# fxp_round_sat_pipe

Pipelined, multi-lane fixed-point rescaler. It is the parametrised successor to the package-level `fxp_round` function. Each lane arithmetic-right-shifts a wide signed product by a runtime shift amount and applies one of four rounding modes. It then narrows the result to the output word, either saturating or wrapping, and flags overflow. It sits between the CORDIC/rotation multipliers and the Jacobi matrix memory, and its valid/ready handshake supports backpressure.

## Interface
Parameters:
- `IN_WIDTH`, default `FXP_MAX_WIDTH` (64): signed input word width per lane.
- `OUT_WIDTH`, default `JACOBI_OUTPUT_WORD_WIDTH` (20): signed output word width per lane.
- `N_LANES`, default `JACOBI_PAIR` (2): number of independent lanes sharing one handshake.
- `SHIFT_WIDTH`, default `$clog2(IN_WIDTH)`: width of the `shift` port.

Ports:
- `clk`  in  1  clock. Single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  input beat accepted when high together with `in_valid`.
- `in_data`  in  `N_LANES*IN_WIDTH`  signed lanes; lane k occupies bits `[k*IN_WIDTH +: IN_WIDTH]`.
- `shift`  in  `SHIFT_WIDTH`  right-shift amount N. Sampled with the beat.
- `mode`  in  `rnd_mode_t` (2)  rounding mode. Sampled with the beat.
- `sat_en`  in  1  1 = saturate on overflow, 0 = wrap. Sampled with the beat.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  downstream accepts the output beat.
- `out_data`  out  `N_LANES*OUT_WIDTH`  signed results, using the same lane packing as `in_data`.
- `out_ovf`  out  `N_LANES`  per-lane overflow flag for the current output beat.
- `ovf_sticky`  out  `N_LANES`  per-lane OR of all `out_ovf` values transferred since reset or the last `ovf_clear`.
- `ovf_clear`  in  1  clears `ovf_sticky`.

## Operation
- **Shift clamp.** Shift values greater than `IN_WIDTH-1` are clamped to `IN_WIDTH-1`.
- **Zero shift.** When N = 0, no rounding is applied in any mode. Only the narrowing step runs.
- **Rounding.** Rounding is computed in `IN_WIDTH+1` bits so that no intermediate overflow can occur. Let q = x >>> N (floor), r = the dropped bits, and h = 1 << (N-1).
  - `RND_TRUNC`: result is q.
  - `RND_HALF_UP`: result is (x + h) >>> N. This is bit-exact with the legacy `fxp_round`, except that it does not wrap at the positive extreme.
  - `RND_CONV`: result is q+1 if r > h, or if r == h and q is odd; otherwise q.
  - `RND_HALF_AWAY`: a tie (r == h) goes to q+1 when x ≥ 0 and stays at q when x < 0. Non-ties are rounded to nearest.
- **Narrowing.** The result is in range when it lies in [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Out of range: `out_ovf[k]` = 1.
  - With `sat_en` = 1, the output is clamped to the nearest bound.
  - With `sat_en` = 0, the output is the low `OUT_WIDTH` bits of the result.
- **Sticky flags.** `ovf_sticky[k]` sets on any transferred beat (`out_valid && out_ready`) with `out_ovf[k]` = 1.
  - When `ovf_clear` and a setting event occur in the same cycle, set wins, so the flag ends at 1.
- **Lane independence.** The lanes are fully independent. All lanes share `shift`, `mode` and `sat_en`.

## Timing
- **Pipeline.** Two stages.
  - S1 registers the rounded value, together with `sat_en` and the valid bit.
  - S2 registers the narrowed data, `out_ovf` and the valid bit. S2 drives the outputs directly.
- **Latency.** An accepted beat appears on `out_valid` exactly 2 cycles later when there are no stalls. Throughput is 1 beat per cycle.
- **Stage advance.**
  - adv2 = !s2_valid || out_ready
  - adv1 = !s1_valid || adv2
  - `in_ready` = adv1
- **Bubble collapse.** A stalled S2 does not block S1 when S1 is empty. There is a combinational path from `out_ready` to `in_ready`, and this path is intentional.
- **Handshake rules.**
  - `out_data`, `out_ovf` and `out_valid` hold stable while `out_valid && !out_ready`.
  - Beats are never dropped, duplicated or reordered.
- **Reset.** In the cycle after `rst`, `out_valid` = 0, `in_ready` = 1, `out_data` = 0, `out_ovf` = 0 and `ovf_sticky` = 0.
  - A reset asserted mid-stream discards all in-flight beats.
  - An input beat presented in a reset cycle is not accepted.

## Structure
- **Shared package additions (`common`):**
  - `typedef enum logic [1:0] {RND_TRUNC, RND_HALF_UP, RND_CONV, RND_HALF_AWAY} rnd_mode_t`
  - `FXP_SHIFT_WIDTH = $clog2(FXP_MAX_WIDTH)`
  - The existing `fxp_round` function stays, as the reference for `RND_HALF_UP`.
- **Sub-module.** `fxp_round_lane` is combinational. It takes x, N, mode and sat_en, and outputs the rounded value, the narrowed value and ovf; it splits into a round stage and a narrow stage. The top level generates `N_LANES` instances and owns the pipeline registers, the handshake and the sticky logic.

## Test plan
- **Rounding modes.** N = 15, x = 0x4000 (+0.5) gives TRUNC 0 / HALF_UP 1 / CONV 0 / HALF_AWAY 1. x = -0x4000 gives -1 / 0 / 0 / -1. x = 0x14000 (2.5) gives 2 / 3 / 2 / 3.
- **Saturation.** `OUT_WIDTH` = 20, N = 15, x = 2^40.
  - With `sat_en` = 1: out = 524287, `out_ovf` = 1.
  - With `sat_en` = 0: out = 0 (wrap), `out_ovf` = 1.
  - x = -2^40 with `sat_en` = 1 gives -524288.
- **Edge shifts.** N = 0, x = 12345 gives 12345 in all modes with `ovf` = 0. N = 63 is applied as given. N = 70 with `SHIFT_WIDTH` = 7 is clamped to 63. x = `IN_WIDTH` max with HALF_UP at N = 1 does not wrap negative.
- **Backpressure.** Offer 6 consecutive beats while `out_ready` is held low for 5 cycles.
  - Exactly 2 beats are accepted, then `in_ready` stays 0.
  - After release, all 6 beats emerge in order with stable data during the stall.
- **Sticky flags.** An ovf beat on lane 1 only gives `ovf_sticky` = 2'b10.
  - `ovf_clear` alone clears it to 0.
  - `ovf_clear` in the same cycle as a new ovf transfer leaves it at 1.
- **Reset mid-stream.** Assert `rst` for 1 cycle with 2 beats in flight. The next cycle shows `out_valid` = 0, `in_ready` = 1 and `ovf_sticky` = 0, and neither beat ever emerges.
